// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes and the frame state encoding,
// used by the transmitter and the future receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_BIT,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte-side handshake of the UART transmitter: request/payload in, line and
// frame status out.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);

  logic                 START;
  logic [DATA_BITS-1:0] DATA;
  logic                 TXD;
  logic                 BUSY;
  logic                 DONE;

  modport master (
    output START,
    output DATA,
    input  TXD,
    input  BUSY,
    input  DONE
  );

  modport slave (
    input  START,
    input  DATA,
    output TXD,
    output BUSY,
    output DONE
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Per-bit clock enable: tick is high in the last cycle of every DIV-cycle slot.
// clear holds the counter at zero so a frame always starts on a fresh slot.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_baud_tick: DIV must be at least 2");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (DATA_BITS, parity, 1/2 stop bits) driven by a
// baud clock-enable; one-cycle acceptance latency and a DONE pulse per frame.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 48000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_cfg_if.slave  bus
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_par_chk
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  uart_state_t          state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [BW-1:0]        bit_idx, bit_idx_nxt;
  logic                 stop_idx, stop_idx_nxt;
  logic                 par, par_nxt;
  logic                 txd, txd_nxt;
  logic                 tick;
  logic                 clear;
  logic                 done;

  // Counter is held in reset while idle, so the start bit gets a full DIV slot.
  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .CLK   (CLK),
    .RST   (RST),
    .clear (clear),
    .tick  (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par      <= 1'b0;
      txd      <= 1'b1;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_idx <= stop_idx_nxt;
      par      <= par_nxt;
      txd      <= txd_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    par_nxt      = par;
    txd_nxt      = txd;
    clear        = (state == ST_IDLE);
    done         = 1'b0;

    case (state)
      ST_IDLE: begin
        txd_nxt = 1'b1;
        if (bus.START) begin
          state_nxt   = ST_START_BIT;
          shreg_nxt   = bus.DATA;
          par_nxt     = ^bus.DATA;
          bit_idx_nxt = '0;
          txd_nxt     = 1'b0;
        end
      end
      ST_START_BIT: begin
        if (tick) begin
          state_nxt   = ST_DATA;
          txd_nxt     = shreg[0];
          shreg_nxt   = shreg >> 1;
          bit_idx_nxt = BW'(1);
        end
      end
      ST_DATA: begin
        // bit_idx counts bits already placed on the line
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
            if (PARITY != PAR_NONE) begin
              state_nxt = ST_PARITY;
              txd_nxt   = (PARITY == PAR_ODD) ? ~par : par;
            end else begin
              state_nxt    = ST_STOP;
              txd_nxt      = 1'b1;
              stop_idx_nxt = 1'b0;
            end
          end else begin
            txd_nxt     = shreg[0];
            shreg_nxt   = shreg >> 1;
            bit_idx_nxt = bit_idx + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_nxt    = ST_STOP;
          txd_nxt      = 1'b1;
          stop_idx_nxt = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_idx == LAST_STOP) begin
            state_nxt = ST_IDLE;
            done      = 1'b1;
          end else begin
            stop_idx_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        txd_nxt   = 1'b1;
      end
    endcase
  end

  assign bus.TXD  = txd;
  assign bus.BUSY = (state != ST_IDLE);
  assign bus.DONE = done;

endmodule
